lsu_mem_ctrl: RTL

Load/store initiator in the MEM stage. It takes one pipeline memory request at a time, covering RV32I LB/LH/LW/LBU/LHU/SB/SH/SW. It drives the word-only data-memory port, which has combinational read and write on the clock edge, and returns aligned, extended load data through a valid/ready response. Sub-word stores are done as read-modify-write because the memory writes whole words only.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu_mem_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared funct3 codes, FSM state type and request-decode helpers
//                for the load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    // Unsigned widths exist only for loads.
    function automatic logic is_legal(input logic store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: is_legal = 1'b1;
            F3_BU, F3_HU:     is_legal = !store;
            default:          is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: is_misaligned = addr_lo[0];
            F3_W:        is_misaligned = (addr_lo != 2'b00);
            default:     is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_align.sv
// ============================================================================
//  Module      : lsu_align
//  Description : Little-endian lane extract/extend for loads and lane merge for
//                sub-word stores. Purely combinational.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[{lane, 3'b000} +: 8];
        w_half = lane[1] ? word[31:16] : word[15:0];

        load_data = word;
        case (funct3)
            F3_B:    load_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   load_data = {24'd0, w_byte};
            F3_H:    load_data = {{16{w_half[15]}}, w_half};
            F3_HU:   load_data = {16'd0, w_half};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3[1:0])
            2'b00: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lane[1]) store_word[31:16] = wdata[15:0];
                else         store_word[15:0]  = wdata[15:0];
            end
            default: store_word = wdata;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
// ============================================================================
//  Module      : lsu_mem_ctrl
//  Description : MEM-stage load/store initiator for a word-only memory port;
//                sub-word stores are performed as read-modify-write.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int XLEN          = 32,
    parameter bit MISALIGN_TRAP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            busy,
    output logic            mem_w_en,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_d,
    input  logic [XLEN-1:0] mem_r_d
);

    lsu_state_t      state_q, state_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;

    logic            w_req_err;
    logic [XLEN-1:0] w_req_addr;
    logic [XLEN-1:0] w_load_data;
    logic [XLEN-1:0] w_store_word;

    lsu_align u_align (
        .word       (mem_r_d),
        .wdata      (wdata_q),
        .funct3     (funct3_q),
        .lane       (addr_q[1:0]),
        .load_data  (w_load_data),
        .store_word (w_store_word)
    );

    // Natural alignment is forced unconditionally: with trapping enabled any
    // access it would alter has already been flagged as an error.
    always_comb begin
        w_req_err  = !is_legal(req_store, req_funct3) ||
                     (MISALIGN_TRAP && is_misaligned(req_funct3, req_addr[1:0]));
        w_req_addr = req_addr;
        case (req_funct3[1:0])
            2'b01:   w_req_addr[0]   = 1'b0;
            2'b10:   w_req_addr[1:0] = 2'b00;
            default: w_req_addr      = req_addr;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = w_req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = w_req_err;
                    if (w_req_err)
                        state_d = ST_RESP;
                    else if (req_store && (req_funct3 == F3_W))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (store_q) begin
                    wdata_d = w_store_word;
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = w_load_data;
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP: begin
                if (resp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Every output is decoded from state_q so the async reset clears them at once.
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign resp_err   = (state_q == ST_RESP) && err_q;
    assign mem_w_en   = (state_q == ST_WRITE);
    assign mem_addr   = ((state_q == ST_READ) || (state_q == ST_WRITE)) ?
                        {addr_q[XLEN-1:2], 2'b00} : '0;
    assign mem_w_d    = (state_q == ST_WRITE) ? wdata_q : '0;

endmodule

`default_nettype wire
